// File: rtl/tb_vec_pkg.sv
// Shared types and constants for the vector driver and its delay line.
package tb_vec_pkg;

    localparam int LAT_MAX   = 8;
    localparam int ERR_CNT_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } tb_vec_state_t;

endpackage

// File: rtl/tb_delay_line.sv
// LAT-stage register pipe that carries compare context alongside the DUT latency.
module tb_delay_line #(
    parameter int LAT = 2,
    parameter int W   = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush_i,
    input  logic         in_valid_i,
    input  logic [W-1:0] in_data_i,
    output logic         out_valid_o,
    output logic [W-1:0] out_data_o
);

    logic [LAT-1:0] vld_q;
    logic [W-1:0]   dat_q [LAT];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            for (int i = 0; i < LAT; i++) dat_q[i] <= '0;
        end else if (flush_i) begin
            // Payload may stay stale; only the valid bits gate the compare.
            vld_q <= '0;
        end else begin
            vld_q[0] <= in_valid_i;
            dat_q[0] <= in_data_i;
            for (int i = 1; i < LAT; i++) begin
                vld_q[i] <= vld_q[i-1];
                dat_q[i] <= dat_q[i-1];
            end
        end
    end

    assign out_valid_o = vld_q[LAT-1];
    assign out_data_o  = dat_q[LAT-1];

endmodule

// File: rtl/tb_vec_driver.sv
// Plays a stored vector table onto a DUT input bus and checks the masked
// responses after a fixed latency, reporting error count and first failure.
module tb_vec_driver
    import tb_vec_pkg::*;
#(
    parameter  int IN_W  = 32,
    parameter  int OUT_W = 8,
    parameter  int DEPTH = 16,
    parameter  int LAT   = 2,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 wr_en,
    input  logic [AW-1:0]        wr_addr,
    input  logic [IN_W-1:0]      wr_stim,
    input  logic [OUT_W-1:0]     wr_exp,
    input  logic [OUT_W-1:0]     wr_mask,
    input  logic [AW:0]          num_vec,
    input  logic                 start,
    input  logic                 abort,
    output logic [IN_W-1:0]      dut_in,
    output logic                 dut_in_valid,
    input  logic [OUT_W-1:0]     dut_out,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [ERR_CNT_W-1:0] err_cnt,
    output logic [AW-1:0]        first_err_idx,
    output logic                 first_err_valid
);

    localparam int DW = $clog2(LAT_MAX);
    localparam int PW = AW + 2 * OUT_W;

    logic [IN_W-1:0]  stim_mem [DEPTH];
    logic [OUT_W-1:0] exp_mem  [DEPTH];
    logic [OUT_W-1:0] mask_mem [DEPTH];

    tb_vec_state_t        state_q, state_d;
    logic [AW-1:0]        idx_q, idx_d;
    logic [AW:0]          num_q, num_d;
    logic [DW-1:0]        drn_q, drn_d;
    logic [IN_W-1:0]      hold_q, hold_d;
    logic [ERR_CNT_W-1:0] err_q, err_d;
    logic [AW-1:0]        fidx_q, fidx_d;
    logic                 fval_q, fval_d;
    logic                 pass_q, pass_d;

    logic [AW:0]      num_clamp;
    logic             flush;
    logic             dl_vld;
    logic [PW-1:0]    dl_in, dl_out;
    logic [AW-1:0]    dl_idx;
    logic [OUT_W-1:0] dl_exp, dl_mask;
    logic             mismatch;

    always_ff @(posedge clk) begin
        if (wr_en && state_q == ST_IDLE) begin
            stim_mem[wr_addr] <= wr_stim;
            exp_mem[wr_addr]  <= wr_exp;
            mask_mem[wr_addr] <= wr_mask;
        end
    end

    assign num_clamp = (num_vec > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : num_vec;
    assign flush     = abort && (state_q == ST_RUN || state_q == ST_DRAIN);
    assign dl_in     = {idx_q, exp_mem[idx_q], mask_mem[idx_q]};

    tb_delay_line #(.LAT(LAT), .W(PW)) u_dly (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush_i    (flush),
        .in_valid_i (state_q == ST_RUN),
        .in_data_i  (dl_in),
        .out_valid_o(dl_vld),
        .out_data_o (dl_out)
    );

    assign dl_idx   = dl_out[PW-1 -: AW];
    assign dl_exp   = dl_out[2*OUT_W-1 -: OUT_W];
    assign dl_mask  = dl_out[OUT_W-1:0];
    assign mismatch = dl_vld && (|((dut_out ^ dl_exp) & dl_mask));

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        num_d   = num_q;
        drn_d   = drn_q;
        hold_d  = hold_q;
        err_d   = err_q;
        fidx_d  = fidx_q;
        fval_d  = fval_q;
        pass_d  = pass_q;

        if (mismatch) begin
            if (err_q != '1) err_d = err_q + ERR_CNT_W'(1);
            if (!fval_q) begin
                fidx_d = dl_idx;
                fval_d = 1'b1;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    num_d   = num_clamp;
                    err_d   = '0;
                    fval_d  = 1'b0;
                    pass_d  = 1'b0;
                    idx_d   = '0;
                    drn_d   = '0;
                    state_d = (num_clamp == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                hold_d = stim_mem[idx_q];
                if ({1'b0, idx_q} == num_q - (AW+1)'(1)) begin
                    state_d = ST_DRAIN;
                    drn_d   = '0;
                end else begin
                    idx_d = idx_q + AW'(1);
                end
            end
            ST_DRAIN: begin
                if (drn_q == DW'(LAT - 1)) state_d = ST_DONE;
                else                       drn_d   = drn_q + DW'(1);
            end
            ST_DONE: begin
                pass_d  = (err_q == '0);
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (flush) begin
            state_d = ST_IDLE;
            pass_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            num_q   <= '0;
            drn_q   <= '0;
            hold_q  <= '0;
            err_q   <= '0;
            fidx_q  <= '0;
            fval_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            num_q   <= num_d;
            drn_q   <= drn_d;
            hold_q  <= hold_d;
            err_q   <= err_d;
            fidx_q  <= fidx_d;
            fval_q  <= fval_d;
            pass_q  <= pass_d;
        end
    end

    // The verdict is already known in DONE, so expose it alongside the pulse.
    assign dut_in          = (state_q == ST_RUN) ? stim_mem[idx_q] : hold_q;
    assign dut_in_valid    = (state_q == ST_RUN);
    assign busy            = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign done            = (state_q == ST_DONE);
    assign pass            = (state_q == ST_DONE) ? (err_q == '0) : pass_q;
    assign err_cnt         = err_q;
    assign first_err_idx   = fidx_q;
    assign first_err_valid = fval_q;

endmodule
